// File: rtl/audio_mixer_pkg.sv
// Shared constants and helpers for the TurboSound audio mixer.
package audio_mixer_pkg;

    localparam int PCM_W = 12;

    typedef enum logic [1:0] {
        MODE_MONO  = 2'b00,
        MODE_ABC   = 2'b01,
        MODE_ACB   = 2'b10,
        MODE_MONO2 = 2'b11
    } stereo_mode_e;

    localparam logic [2:0] SLOT_AY1_A = 3'd0;
    localparam logic [2:0] SLOT_AY1_B = 3'd1;
    localparam logic [2:0] SLOT_AY1_C = 3'd2;
    localparam logic [2:0] SLOT_AY2_A = 3'd3;
    localparam logic [2:0] SLOT_AY2_B = 3'd4;
    localparam logic [2:0] SLOT_AY2_C = 3'd5;
    localparam logic [2:0] SLOT_SPK   = 3'd6;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;

    localparam int unsigned SPK_W_DEF = 96;
    localparam int unsigned EAR_W_DEF = 32;
    localparam int unsigned MIC_W_DEF = 8;

    function automatic logic [PCM_W-1:0] sat_add(input logic [PCM_W-1:0] a,
                                                 input logic [PCM_W-1:0] b);
        logic [PCM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[PCM_W] ? '1 : s[PCM_W-1:0];
    endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator: output ones density equals pcm / 2**W.
module sigma_delta_dac
    import audio_mixer_pkg::*;
#(
    parameter int W = PCM_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] pcm,
    output logic         dac_out
);

    logic [W-1:0] acc_q;
    logic [W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, pcm};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            dac_out <= 1'b0;
        end else begin
            acc_q   <= sum[W-1:0];
            dac_out <= sum[W];
        end
    end

endmodule

// File: rtl/turbosound_mixer.sv
// Time-multiplexed stereo mixer for dual AY + beeper/EAR/MIC, feeding two sigma-delta DACs.
//   state | meaning
//   IDLE  | waiting for clk175en, inputs snapshotted on it
//   ACC   | one slot accumulated per clock, slots 0..6
//   PUB   | accumulators copied to the PCM outputs, strobe pulsed
module turbosound_mixer
    import audio_mixer_pkg::*;
#(
    parameter int unsigned SPK_W = SPK_W_DEF,
    parameter int unsigned EAR_W = EAR_W_DEF,
    parameter int unsigned MIC_W = MIC_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk175en,
    input  logic [23:0]      ay1_splitted,
    input  logic [23:0]      ay2_splitted,
    input  logic             disable_turboay,
    input  logic             beeper,
    input  logic             ear,
    input  logic             mic,
    input  logic [1:0]       stereo_mode,
    output logic [PCM_W-1:0] left_pcm,
    output logic [PCM_W-1:0] right_pcm,
    output logic             sample_strobe,
    output logic             busy,
    output logic             audio_left,
    output logic             audio_right
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_PUB} state_e;

    localparam logic [PCM_W-1:0] SPK_LVL = PCM_W'(SPK_W);
    localparam logic [PCM_W-1:0] EAR_LVL = PCM_W'(EAR_W);
    localparam logic [PCM_W-1:0] MIC_LVL = PCM_W'(MIC_W);

    state_e           state_q, state_d;
    logic [2:0]       slot_q;
    logic [23:0]      ay1_q, ay2_q;
    logic             dis_q, beeper_q, ear_q, mic_q;
    stereo_mode_e     mode_q;
    logic [PCM_W-1:0] acc_l_q, acc_r_q;
    logic [PCM_W-1:0] level, spk_level, add_l, add_r;
    logic [1:0]       chan;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (clk175en) state_d = ST_ACC;
            ST_ACC:  if (slot_q == SLOT_SPK) state_d = ST_PUB;
            ST_PUB:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        spk_level = (beeper_q ? SPK_LVL : '0) + (ear_q ? EAR_LVL : '0) + (mic_q ? MIC_LVL : '0);
    end

    always_comb begin
        level = '0;
        chan  = CH_A;
        add_l = '0;
        add_r = '0;
        case (slot_q)
            SLOT_AY1_A: begin level = {4'd0, ay1_q[23:16]}; chan = CH_A; end
            SLOT_AY1_B: begin level = {4'd0, ay1_q[15:8]};  chan = CH_B; end
            SLOT_AY1_C: begin level = {4'd0, ay1_q[7:0]};   chan = CH_C; end
            SLOT_AY2_A: begin level = dis_q ? '0 : {4'd0, ay2_q[23:16]}; chan = CH_A; end
            SLOT_AY2_B: begin level = dis_q ? '0 : {4'd0, ay2_q[15:8]};  chan = CH_B; end
            SLOT_AY2_C: begin level = dis_q ? '0 : {4'd0, ay2_q[7:0]};   chan = CH_C; end
            default:    level = spk_level;
        endcase
        // The speaker slot is centred regardless of stereo mode.
        if (slot_q >= SLOT_SPK) begin
            add_l = level;
            add_r = level;
        end else begin
            case (mode_q)
                MODE_ABC: begin
                    add_l = (chan != CH_C) ? level : '0;
                    add_r = (chan != CH_A) ? level : '0;
                end
                MODE_ACB: begin
                    add_l = (chan != CH_B) ? level : '0;
                    add_r = (chan != CH_A) ? level : '0;
                end
                default: begin
                    add_l = level;
                    add_r = level;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q        <= '0;
            ay1_q         <= '0;
            ay2_q         <= '0;
            dis_q         <= 1'b0;
            beeper_q      <= 1'b0;
            ear_q         <= 1'b0;
            mic_q         <= 1'b0;
            mode_q        <= MODE_MONO;
            acc_l_q       <= '0;
            acc_r_q       <= '0;
            left_pcm      <= '0;
            right_pcm     <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= (state_q == ST_PUB);
            case (state_q)
                ST_IDLE: if (clk175en) begin
                    ay1_q    <= ay1_splitted;
                    ay2_q    <= ay2_splitted;
                    dis_q    <= disable_turboay;
                    beeper_q <= beeper;
                    ear_q    <= ear;
                    mic_q    <= mic;
                    mode_q   <= stereo_mode_e'(stereo_mode);
                    acc_l_q  <= '0;
                    acc_r_q  <= '0;
                    slot_q   <= '0;
                end
                ST_ACC: begin
                    acc_l_q <= sat_add(acc_l_q, add_l);
                    acc_r_q <= sat_add(acc_r_q, add_r);
                    slot_q  <= slot_q + 3'd1;
                end
                ST_PUB: begin
                    left_pcm  <= acc_l_q;
                    right_pcm <= acc_r_q;
                end
                default: ;
            endcase
        end
    end

    sigma_delta_dac #(.W(PCM_W)) u_dac_left (
        .clk     (clk),
        .reset_n (reset_n),
        .pcm     (left_pcm),
        .dac_out (audio_left)
    );

    sigma_delta_dac #(.W(PCM_W)) u_dac_right (
        .clk     (clk),
        .reset_n (reset_n),
        .pcm     (right_pcm),
        .dac_out (audio_right)
    );

endmodule

// File: tb/tb_turbosound_mixer.sv
// Scoreboard bench for turbosound_mixer: expected samples queued at clk175en, checked on sample_strobe.
`timescale 1ns/1ps
module tb_turbosound_mixer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk175en = 1'b0;
    logic [23:0] ay1_splitted = '0;
    logic [23:0] ay2_splitted = '0;
    logic        disable_turboay = 1'b0;
    logic        beeper = 1'b0;
    logic        ear = 1'b0;
    logic        mic = 1'b0;
    logic [1:0]  stereo_mode = 2'b00;
    logic [11:0] left_pcm, right_pcm;
    logic        sample_strobe, busy, audio_left, audio_right;

    turbosound_mixer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .clk175en        (clk175en),
        .ay1_splitted    (ay1_splitted),
        .ay2_splitted    (ay2_splitted),
        .disable_turboay (disable_turboay),
        .beeper          (beeper),
        .ear             (ear),
        .mic             (mic),
        .stereo_mode     (stereo_mode),
        .left_pcm        (left_pcm),
        .right_pcm       (right_pcm),
        .sample_strobe   (sample_strobe),
        .busy            (busy),
        .audio_left      (audio_left),
        .audio_right     (audio_right)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] l;
        logic [11:0] r;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   strobe_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [23:0] a1, input logic [23:0] a2,
                                  input logic dis, input logic bp, input logic e,
                                  input logic m, input logic [1:0] mode,
                                  output logic [11:0] l, output logic [11:0] r);
        int lv, rv, a, b, c, spk;
        logic [23:0] ay;
        lv = 0;
        rv = 0;
        for (int k = 0; k < 2; k++) begin
            ay = (k == 0) ? a1 : a2;
            if (!(k == 1 && dis)) begin
                a = int'(ay[23:16]);
                b = int'(ay[15:8]);
                c = int'(ay[7:0]);
                case (mode)
                    2'b01:   begin lv += a + b; rv += b + c; end
                    2'b10:   begin lv += a + c; rv += b + c; end
                    default: begin lv += a + b + c; rv += a + b + c; end
                endcase
            end
        end
        spk = (bp ? 96 : 0) + (e ? 32 : 0) + (m ? 8 : 0);
        lv += spk;
        rv += spk;
        l = (lv > 4095) ? 12'hfff : 12'(lv);
        r = (rv > 4095) ? 12'hfff : 12'(rv);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && sample_strobe === 1'b1) begin
            strobe_cnt++;
            if (sb.size() == 0) begin
                chk("strobe_unexpected", 32'(sample_strobe), 0);
            end else begin
                e = sb.pop_front();
                chk("left_pcm", 32'(left_pcm), 32'(e.l));
                chk("right_pcm", 32'(right_pcm), 32'(e.r));
            end
        end
    end

    task automatic run_sample(input string tag, input logic [23:0] a1, input logic [23:0] a2,
                              input logic dis, input logic bp, input logic e, input logic m,
                              input logic [1:0] mode, input bit perturb);
        exp_t x;
        logic [11:0] el, er;
        int busy_cnt, s0, it;
        model(a1, a2, dis, bp, e, m, mode, el, er);
        x.l = el;
        x.r = er;
        @(negedge clk);
        ay1_splitted = a1; ay2_splitted = a2; disable_turboay = dis;
        beeper = bp; ear = e; mic = m; stereo_mode = mode;
        clk175en = 1'b1;
        sb.push_back(x);
        s0 = strobe_cnt;
        @(negedge clk);
        clk175en = 1'b0;
        busy_cnt = 0;
        it = 0;
        while (it < 20 && sb.size() != 0) begin
            if (busy === 1'b1) busy_cnt++;
            // Mid-sample input change plus a stray enable, both must be ignored.
            if (perturb && it == 3) begin
                ay1_splitted = 24'($urandom); ay2_splitted = 24'($urandom);
                disable_turboay = 1'($urandom); beeper = 1'($urandom);
                ear = 1'($urandom); mic = 1'($urandom); stereo_mode = 2'($urandom);
                clk175en = 1'b1;
            end
            if (perturb && it == 4) clk175en = 1'b0;
            @(negedge clk);
            #1;
            it++;
        end
        chk({tag, "_done"}, 32'(sb.size()), 0);
        sb.delete();
        chk({tag, "_latency"}, 32'(it), 8);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 8);
        chk({tag, "_strobes"}, 32'(strobe_cnt - s0), 1);
        @(negedge clk);
        chk({tag, "_strobe_width"}, 32'(sample_strobe), 0);
        chk({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ones_l, ones_r, s0;

        @(negedge clk);
        chk("rst_left_pcm", 32'(left_pcm), 0);
        chk("rst_right_pcm", 32'(right_pcm), 0);
        chk("rst_strobe", 32'(sample_strobe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_audio_left", 32'(audio_left), 0);
        chk("rst_audio_right", 32'(audio_right), 0);
        reset_n = 1'b1;

        ones_l = 0;
        ones_r = 0;
        repeat (50) begin
            @(negedge clk);
            if (audio_left === 1'b1) ones_l++;
            if (audio_right === 1'b1) ones_r++;
        end
        chk("idle_audio_left_ones", 32'(ones_l), 0);
        chk("idle_audio_right_ones", 32'(ones_r), 0);
        chk("idle_strobes", 32'(strobe_cnt), 0);
        chk("idle_left_pcm", 32'(left_pcm), 0);

        run_sample("abc", {8'd100, 8'd50, 8'd20}, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        run_sample("mono_full", {3{8'd255}}, {3{8'd255}}, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        run_sample("mono_noay2", {3{8'd255}}, {3{8'd255}}, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0);
        run_sample("acb", 24'd0, {8'd10, 8'd20, 8'd30}, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        run_sample("acb_perturb", 24'd0, {8'd10, 8'd20, 8'd30}, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1);

        for (int k = 0; k < 6; k++) begin
            run_sample("rand", 24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), 2'($urandom), 1'b0);
        end

        run_sample("pcm1024", {3{8'd200}}, {8'd200, 8'd200, 8'd24}, 1'b0, 1'b0, 1'b0, 1'b0,
                   2'b00, 1'b0);
        ones_l = 0;
        ones_r = 0;
        repeat (4096) begin
            @(negedge clk);
            if (audio_left === 1'b1) ones_l++;
            if (audio_right === 1'b1) ones_r++;
        end
        chk("sd_left_ones_1024", 32'(ones_l), 1024);
        chk("sd_right_ones_1024", 32'(ones_r), 1024);

        @(negedge clk);
        ay1_splitted = {8'd100, 8'd50, 8'd20}; ay2_splitted = '0; disable_turboay = 1'b0;
        beeper = 1'b0; ear = 1'b0; mic = 1'b0; stereo_mode = 2'b01;
        clk175en = 1'b1;
        @(negedge clk);
        clk175en = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_left_pcm", 32'(left_pcm), 0);
        chk("midrst_right_pcm", 32'(right_pcm), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_strobe", 32'(sample_strobe), 0);
        chk("midrst_audio_left", 32'(audio_left), 0);
        chk("midrst_audio_right", 32'(audio_right), 0);
        s0 = strobe_cnt;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_no_strobe", 32'(strobe_cnt - s0), 0);
        chk("midrst_pcm_held", 32'(left_pcm), 0);

        run_sample("after_rst", {8'd100, 8'd50, 8'd20}, {8'd1, 8'd2, 8'd3}, 1'b0, 1'b1, 1'b0,
                   1'b1, 2'b01, 1'b0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/turbosound_mixer.md
# turbosound_mixer

Downstream audio stage for the dual-AY TurboSound block. It takes the six 8-bit AY channel levels plus the beeper, EAR and MIC bits, and mixes them into 12-bit left/right PCM samples according to a stereo mode. Mixing is time-multiplexed: one accumulation slot per clock after each 1.75 MHz enable. Each PCM sample drives a first-order sigma-delta modulator that produces the 1-bit audio pins.

## Interface

Parameters:
- `SPK_W`, 96: additive level of the beeper bit when high.
- `EAR_W`, 32: additive level of the EAR bit when high.
- `MIC_W`, 8: additive level of the MIC bit when high.

Ports:
- `clk`, in, 1: system clock (28 MHz domain); the only clock.
- `reset_n`, in, 1: reset, asynchronous and active-low.
- `clk175en`, in, 1: one-cycle sample-start enable; consecutive pulses are at least 9 clocks apart.
- `ay1_splitted`, in, 24: AY1 channel levels; [23:16] A, [15:8] B, [7:0] C.
- `ay2_splitted`, in, 24: AY2 channel levels, same layout as `ay1_splitted`.
- `disable_turboay`, in, 1: when 1, AY2 contributes zero.
- `beeper`, in, 1: speaker bit.
- `ear`, in, 1: EAR bit.
- `mic`, in, 1: MIC bit.
- `stereo_mode`, in, 2: 00 mono, 01 ABC, 10 ACB, 11 mono.
- `left_pcm`, out, 12: last published left sample.
- `right_pcm`, out, 12: last published right sample.
- `sample_strobe`, out, 1: one-cycle pulse when new PCM values are published.
- `busy`, out, 1: high while accumulation is in progress.
- `audio_left`, out, 1: sigma-delta bitstream for the left channel.
- `audio_right`, out, 1: sigma-delta bitstream for the right channel.

## Operation

Sequencer FSM has three states: IDLE, ACC, PUB.
- IDLE: on `clk175en`, snapshot all audio inputs, `stereo_mode` and `disable_turboay` into registers. Clear both accumulators, set slot to 0, go to ACC.
- ACC: each cycle, add the contribution for the current slot, then increment the slot. Slot 0..6 order: AY1 A, AY1 B, AY1 C, AY2 A, AY2 B, AY2 C, SPK. After slot 6, go to PUB.
- PUB: copy the accumulators to `left_pcm` and `right_pcm`, pulse `sample_strobe`, go to IDLE.
- `clk175en` outside IDLE is ignored; no queueing.

Routing, applied identically to AY1 and AY2:
- Mono: A, B and C all go to both sides.
- ABC: A to L, B to both, C to R.
- ACB: A to L, C to both, B to R.
- SPK slot: `beeper`·`SPK_W` + `ear`·`EAR_W` + `mic`·`MIC_W`, added to both sides.
- AY2 slots add 0 when the snapshotted `disable_turboay` is 1.

Width rules:
- All operands are zero-extended to 12 bits; accumulators are 12 bits.
- Worst case is 6·255 + 136 = 1666, so no overflow is possible. Saturation logic is still present: clamp at 4095 on carry out.

Sigma-delta modulator, one per side, updated every `clk` regardless of FSM state:
- 13-bit sum = {1'b0, acc[11:0]} + {1'b0, pcm}.
- acc ← sum[11:0]; output bit ← sum[12].
- Ones density equals pcm/4096.

## Timing

- Reset values: FSM IDLE, slot 0, accumulators 0, `left_pcm`/`right_pcm` 0, `sample_strobe` 0, `busy` 0, modulator accumulators 0, `audio_left`/`audio_right` 0.
- With `clk175en` high at edge N: snapshot at N. ACC runs edges N+1..N+7. PUB is at edge N+8, where `left_pcm`/`right_pcm` update and `sample_strobe` is high for that one cycle.
- `busy` is high from N+1 through N+8 inclusive.
- Input changes after edge N do not affect the sample in progress.
- Modulators use the new PCM value from edge N+9 onward.
- Reset asserted mid-sample: the partial sample is discarded and the outputs return to their reset values immediately (asynchronous).
- `clk175en` coinciding with PUB is ignored.

## Structure

- Shared package `audio_mixer_pkg` holds:
  - the stereo mode encodings;
  - slot index constants;
  - the 12-bit PCM width constant;
  - default speaker weights.
- Sub-module `sigma_delta_dac`, parameterised on width (default 12), instantiated twice (left and right).
- The FSM, slot routing and accumulators live in the top module.

## Test plan

- Reset release, no enable: PCM outputs stay 0, audio pins stay 0, `sample_strobe` never pulses.
- ABC mode, AY1 A=100/B=50/C=20, AY2 all 0, speaker bits 0, pulse `clk175en`: at +8, L=150, R=70, one-cycle strobe, `busy` high for 8 cycles.
- Mono mode, all six channels 255, beeper=ear=mic=1: L=R=1666. Repeat with `disable_turboay`=1: L=R=901.
- ACB mode, AY2 A=10/B=20/C=30, AY1 0, `disable_turboay`=0: L=40, R=50. Change inputs at +3: result is unchanged. A second `clk175en` at +4 is ignored.
- PCM fixed at 1024: over 4096 clocks `audio_left` has exactly 1024 ones. PCM 0 gives a constant 0.
- Assert `reset_n` at +4 mid-sample: outputs return to 0 at once, no strobe. After release, a fresh `clk175en` completes normally.
